imem_loader: RTL
================

# imem_loader

Instruction-memory loader: the write-side counterpart of the instruction memory's read port. Accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit MIPS words, and writes them to consecutive word addresses starting at 0. Holds the CPU off the memory while loading and reports completion or error to the host/boot logic.

## Interface
- DEPTH, 16, number of 32-bit words in instruction memory; legal load lengths are 1..DEPTH
- LEN_W, $clog2(DEPTH+1), width of the length input

- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin a load; sampled only in IDLE
- len  in  LEN_W  number of words to load, sampled with start
- in_valid  in  1  byte available on in_byte
- in_byte  in  8  stream byte
- in_ready  out  1  loader accepts a byte this cycle
- wr_en  out  1  one-cycle memory write strobe
- wr_addr  out  32  word index being written (0, 1, 2, ...)
- wr_data  out  32  assembled instruction word
- busy  out  1  load in progress (not IDLE)
- cpu_hold  out  1  CPU must not fetch; equals busy
- done  out  1  one-cycle pulse, load completed successfully
- err  out  1  level; bad length or checksum failure, cleared by next accepted start

## Operation
- States: IDLE, RECV, WRITE, CHK (only with checksum), DONE.
- IDLE: in_ready=0. On start: if len==0 or len>DEPTH, set err=1, stay IDLE. Otherwise clear err, load word counter=len, wr_addr=0, byte counter=0, XOR accumulator=0 → RECV.
- RECV: in_ready=1. Byte accepted when in_valid&&in_ready. Byte 0 → wr_data[31:24], byte 1 → [23:16], byte 2 → [15:8], byte 3 → [7:0]. Each accepted byte is XORed into the accumulator. After 4th byte accepted → WRITE.
- WRITE: in_ready=0, wr_en=1 with current wr_addr/wr_data for exactly one cycle. Next cycle: wr_addr+1, word counter−1, byte counter=0. If words remain → RECV; else → CHK (macro on) or DONE (macro off).
- DONE: done=1 for one cycle → IDLE. wr_addr retains last-written index+1.
- start while busy ignored; len sampled only at the accepted start.
- in_valid low in RECV: stall indefinitely, no timeout.
- Reset mid-load: all outputs return to reset values immediately; partial words are discarded, already-written words are not rolled back.

## Timing
- Reset values: in_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, cpu_hold=0, done=0, err=0.
- start at edge N → busy=cpu_hold=1 and in_ready=1 from cycle N+1.
- Back-to-back valid bytes: one word per 5 cycles (4 accept + 1 WRITE); in_ready deasserted during WRITE.
- wr_en asserted the cycle after the 4th byte's accepting edge.
- done asserted the cycle after the last WRITE (macro off); busy/cpu_hold fall in the cycle after done.
- err updates at the edge accepting the bad start; it does not pulse done.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined: after the last WRITE, enter CHK with in_ready=1; accept one byte; if it equals the XOR of all data bytes → DONE, else err=1 and → IDLE without done. Loaded words remain written either way.
- Undefined: no CHK state, no trailing byte; last WRITE goes straight to DONE; err only from bad length.

## Test plan
- Reset: drive rst_n=0 with random inputs → all outputs 0; release, no activity without start.
- Single word: start, len=1, bytes 0x20,0x08,0x00,0x05 back-to-back → one wr_en with wr_addr=0, wr_data=0x20080005; done pulses one cycle later; busy falls after done.
- Four words with in_valid gaps of 0–3 cycles → wr_addr 0..3 in order, data correct, no byte lost or duplicated, in_ready=0 during each WRITE.
- Bad length: start with len=0, then len=DEPTH+1 → err=1, busy stays 0, no wr_en; subsequent start with len=2 clears err.
- Reset mid-load: assert rst_n=0 after 2 bytes of word 1 → outputs reset, no wr_en for the partial word; new load from wr_addr=0 succeeds.
- Macro on: len=1, bytes 0x01,0x02,0x04,0x08, checksum 0x0F → done; repeat with 0x0E → err=1, no done, word still written.

Source files
------------

// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles big-endian 32-bit words from a byte stream and writes them
// to word addresses 0..len-1. Optional trailing XOR checksum byte: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned LEN_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_start,
   input  logic [LEN_W-1:0] i_len,
   input  logic             i_in_valid,
   input  logic [7:0]       i_in_byte,
   output logic             o_in_ready,
   output logic             o_wr_en,
   output logic [31:0]      o_wr_addr,
   output logic [31:0]      o_wr_data,
   output logic             o_busy,
   output logic             o_cpu_hold,
   output logic             o_done,
   output logic             o_err
);

   typedef enum logic [2:0] {StIdle, StRecv, StWrite, StChk, StDone} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [LEN_W-1:0] r_words;
   logic [31:0]      r_addr;
   logic [31:0]      r_data;
   logic [1:0]       r_bcnt;
   logic             r_err;
   logic             w_len_ok;
   logic             w_accept;
   logic             w_last_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]       r_xor;
`endif

   assign w_len_ok    = (i_len != '0) && (i_len <= LEN_W'(DEPTH));
   assign w_accept    = i_in_valid && o_in_ready;
   assign w_last_word = (r_words == LEN_W'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      o_in_ready  = 1'b0;
      o_wr_en     = 1'b0;
      o_done      = 1'b0;
      o_busy      = (r_state != StIdle);
      case (r_state)
         StIdle: begin
            if (i_start && w_len_ok) w_state_nxt = StRecv;
         end
         StRecv: begin
            o_in_ready = 1'b1;
            if (w_accept && (r_bcnt == 2'd3)) w_state_nxt = StWrite;
         end
         StWrite: begin
            o_wr_en = 1'b1;
            if (w_last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               w_state_nxt = StChk;
`else
               w_state_nxt = StDone;
`endif
            end else begin
               w_state_nxt = StRecv;
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         StChk: begin
            o_in_ready = 1'b1;
            if (w_accept) w_state_nxt = (i_in_byte == r_xor) ? StDone : StIdle;
         end
`endif
         StDone: begin
            o_done      = 1'b1;
            w_state_nxt = StIdle;
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_words <= '0;
         r_addr  <= '0;
         r_data  <= '0;
         r_bcnt  <= '0;
         r_err   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         r_xor   <= '0;
`endif
      end else begin
         case (r_state)
            StIdle: begin
               if (i_start) begin
                  if (!w_len_ok) begin
                     r_err <= 1'b1;
                  end else begin
                     r_err   <= 1'b0;
                     r_words <= i_len;
                     r_addr  <= '0;
                     r_bcnt  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                     r_xor   <= '0;
`endif
                  end
               end
            end
            StRecv: begin
               if (w_accept) begin
                  // First byte of the stream is the most significant byte of the word.
                  case (r_bcnt)
                     2'd0:    r_data[31:24] <= i_in_byte;
                     2'd1:    r_data[23:16] <= i_in_byte;
                     2'd2:    r_data[15:8]  <= i_in_byte;
                     default: r_data[7:0]   <= i_in_byte;
                  endcase
                  r_bcnt <= r_bcnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  r_xor  <= r_xor ^ i_in_byte;
`endif
               end
            end
            StWrite: begin
               r_addr  <= r_addr + 32'd1;
               r_words <= r_words - LEN_W'(1);
               r_bcnt  <= '0;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            StChk: begin
               if (w_accept && (i_in_byte != r_xor)) r_err <= 1'b1;
            end
`endif
            default: ;
         endcase
      end
   end

   assign o_wr_addr  = r_addr;
   assign o_wr_data  = r_data;
   assign o_cpu_hold = o_busy;
   assign o_err      = r_err;

endmodule
